// File: rtl/multicycle_alu.sv
// multicycle_alu
// ---------------------------------------------------------------------------
// Purpose: a small ALU with a valid/ready handshake on each side. Most
// operations finish one cycle after they are accepted. MUL is an unsigned
// shift-add that handles one multiplier bit per cycle. The result and flags
// are registered and held until the consumer takes them. Operations never
// overlap.
//
// Configuration: define ALU_MUL_EN to build the multiplier (sel = 1001).
// When it is not defined, no multiplier logic is built and sel 1001 is
// reported as an illegal opcode.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   high only in IDLE; a request is taken when in_valid & in_ready
//   A, B       WIDTH-bit operands
//   sel        4-bit opcode
//   Cin        carry-in, used only by ADD
//   out_valid  result registered and held (state DONE)
//   out_ready  consumer takes the result
//   Y          registered result
//   Cout, Negative, Zero, Overflow, Err   registered flags
// ---------------------------------------------------------------------------
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow,
  output logic             Err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOTA = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'b1001;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  // Single-cycle datapath shared by every op except MUL. The extra top bit
  // of the add, subtract and left-shift results is the carry-out or the
  // last bit shifted out.
  logic [SHW-1:0]          shamt;
  logic [WIDTH:0]          add_wide;
  logic [WIDTH:0]          sub_wide;
  logic [WIDTH:0]          shl_wide;
  logic signed [WIDTH-1:0] a_signed;
  logic [WIDTH-1:0]        sra_y;

  assign shamt    = B[SHW-1:0];
  assign add_wide = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign sub_wide = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_wide = {1'b0, A} << shamt;
  assign a_signed = A;
  assign sra_y    = a_signed >>> shamt;

  logic [WIDTH-1:0] res_y;
  logic             res_cout, res_ovf, res_err;

  // Decode the opcode into a result and raw flags. Signed overflow on
  // add/sub is detected from the operand and result sign bits. Opcodes that
  // are not listed (including 1001 here) give Y = 0 with Err set.
  always_comb begin
    res_y    = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    res_err  = 1'b0;
    case (sel)
      OP_AND:  res_y = A & B;
      OP_OR:   res_y = A | B;
      OP_NOTA: res_y = ~A;
      OP_NOR:  res_y = ~(A | B);
      OP_XOR:  res_y = A ^ B;
      OP_NAND: res_y = ~(A & B);
      OP_ADD: begin
        res_y    = add_wide[WIDTH-1:0];
        res_cout = add_wide[WIDTH];
        res_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_wide[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_y    = sub_wide[WIDTH-1:0];
        res_cout = sub_wide[WIDTH];
        res_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_wide[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL: begin
        res_y    = shl_wide[WIDTH-1:0];
        res_cout = shl_wide[WIDTH];
      end
      OP_SHR:  res_y = A >> shamt;
      OP_SRA:  res_y = sra_y;
      default: res_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add multiplier. The multiplicand moves left and the multiplier
  // moves right by one bit each cycle. The full 2*WIDTH product is kept so
  // the upper half can drive Cout.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Next-state and next-output logic. Y and the flags change only when a
  // result is produced. In DONE they hold until the consumer takes the
  // result. IDLE is the only state that accepts a request, so a request
  // that arrives in the consume cycle is not taken.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (sel == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
`endif
            state_d = DONE;
            y_d     = res_y;
            cout_d  = res_cout;
            ovf_d   = res_ovf;
            err_d   = res_err;
            neg_d   = res_y[WIDTH-1];
            zero_d  = ~res_err & (res_y == '0);
`ifdef ALU_MUL_EN
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          y_d     = acc_next[WIDTH-1:0];
          cout_d  = |acc_next[2*WIDTH-1:WIDTH];
          neg_d   = acc_next[WIDTH-1];
          zero_d  = (acc_next[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset has priority: any operation in
  // progress is dropped, and a request that arrives during reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;
  assign Cout      = cout_q;
  assign Negative  = neg_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
// ---------------------------------------------------------------------------
// Self-checking bench for multicycle_alu at WIDTH = 32. Expected results come
// from a behavioural model that uses 64-bit integer arithmetic. It covers the
// reset state, directed corner cases, random operations, backpressure, and a
// reset that arrives while an operation is in progress.
// ---------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A, B;
  logic [3:0]    sel;
  logic          Cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Y;
  logic          Cout, Negative, Zero, Overflow, Err;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .Cin(Cin), .out_valid(out_valid),
    .out_ready(out_ready), .Y(Y), .Cout(Cout), .Negative(Negative),
    .Zero(Zero), .Overflow(Overflow), .Err(Err)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends, even if the handshake deadlocks.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports each mismatch on one line.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model built directly from the operation definitions. The
  // flags are packed as {Cout, Negative, Zero, Overflow, Err}.
  task automatic refModel(input logic [3:0] op, input logic [31:0] a, b,
                          input logic cin, output logic [31:0] y,
                          output logic [4:0] flags, output int lat);
    longint unsigned ua, ub, full;
    longint          sa, sb, ss;
    logic signed [31:0] as_v;
    logic c, o, e;
    int n;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    as_v = a;
    n = int'(b[4:0]);
    y = '0; c = 1'b0; o = 1'b0; e = 1'b0; lat = 1;
    case (op)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2:  y = ~a;
      4'd3:  y = ~(a | b);
      4'd4:  y = a ^ b;
      4'd5:  y = ~(a & b);
      4'd6: begin
        full = ua + ub + longint'(cin);
        y = full[31:0]; c = full[32];
        ss = sa + sb + longint'(cin);
        o = (ss > MAXS) || (ss < MINS);
      end
      4'd7: begin
        full = ua + (~ub & 64'hFFFF_FFFF) + 64'd1;
        y = full[31:0]; c = full[32];
        ss = sa - sb;
        o = (ss > MAXS) || (ss < MINS);
      end
`ifdef ALU_MUL_EN
      4'd9: begin
        full = ua * ub;
        y = full[31:0]; c = (full[63:32] != 32'd0); lat = W + 1;
      end
`endif
      4'd10: begin
        y = a << n;
        c = (n == 0) ? 1'b0 : a[32 - n];
      end
      4'd12: y = a >> n;
      4'd13: y = as_v >>> n;
      default: begin y = '0; e = 1'b1; end
    endcase
    flags = {c, (e ? 1'b0 : y[31]), (e ? 1'b0 : (y == 32'd0)), o, e};
  endtask

  // Runs one full transaction: request, wait for the result, check it,
  // then consume it. Inputs are scrambled after the accept cycle to show
  // that they are ignored.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, b,
                               input logic cin);
    logic [31:0] ey;
    logic [4:0]  ef;
    int          elat;
    int          cycles;
    refModel(op, a, b, cin, ey, ef, elat);
    @(negedge clk);
    checkOutput($sformatf("ready_before op%0d", op), 64'(in_ready), 64'(1));
    sel = op; A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; sel = 4'($urandom); Cin = 1'($urandom);
    cycles = 1;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput($sformatf("latency op%0d", op), 64'(cycles), 64'(elat));
    checkOutput($sformatf("Y op%0d a=%0h b=%0h", op, a, b), 64'(Y), 64'(ey));
    checkOutput($sformatf("flags op%0d a=%0h b=%0h", op, a, b),
                64'({Cout, Negative, Zero, Overflow, Err}), 64'(ef));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput($sformatf("idle_after op%0d", op), 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  // Operand generator that favours sign and carry corner values.
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] hold_y;
  logic [4:0]  hold_f;
  int          hold_lat;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = 32'd3; B = 32'd4; sel = 4'd6; Cin = 1'b0;

    // Reset state. A request held during reset must not be taken.
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset Y", 64'(Y), 64'(0));
    checkOutput("reset flags", 64'({Cout, Negative, Zero, Overflow, Err}), 64'(0));
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset idle", 64'({out_valid, in_ready}), 64'(2'b01));

    // Directed corner cases.
    applyStimulus(4'd6,  32'h7FFF_FFFF, 32'd1, 1'b0);
    applyStimulus(4'd7,  32'd5, 32'd5, 1'b1);
    applyStimulus(4'd9,  32'h0001_0000, 32'h0001_0000, 1'b0);
    applyStimulus(4'd13, 32'h8000_0000, 32'd4, 1'b1);
    applyStimulus(4'd10, 32'h8000_0001, 32'd0, 1'b0);
    applyStimulus(4'd10, 32'h4000_0001, 32'd2, 1'b0);
    applyStimulus(4'd6,  32'hFFFF_FFFF, 32'd0, 1'b1);
    applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    applyStimulus(4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(4'd9,  32'd12345, 32'd678, 1'b0);

    // Random operations compared against the model.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), 1'($urandom));
    end

    // Backpressure: the result is held while out_ready stays low, and new
    // requests are ignored, including one in the consume cycle.
    refModel(4'd4, 32'hA5A5_0F0F, 32'h0FF0_1234, 1'b0, hold_y, hold_f, hold_lat);
    @(negedge clk);
    sel = 4'd4; A = 32'hA5A5_0F0F; B = 32'h0FF0_1234; Cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp out_valid %0d", i), 64'(out_valid), 64'(1));
      checkOutput($sformatf("bp in_ready %0d", i), 64'(in_ready), 64'(0));
      checkOutput($sformatf("bp Y %0d", i), 64'(Y), 64'(hold_y));
      checkOutput($sformatf("bp flags %0d", i),
                  64'({Cout, Negative, Zero, Overflow, Err}), 64'(hold_f));
      sel = 4'($urandom_range(0, 7)); A = $urandom; B = $urandom; Cin = 1'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp consumed idle", 64'({out_valid, in_ready}), 64'(2'b01));
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp stays idle", 64'({out_valid, in_ready}), 64'(2'b01));

    // Load a nonzero Y so the reset-clears-Y check has something to clear.
    applyStimulus(4'd6, 32'd3, 32'd4, 1'b0);

`ifdef ALU_MUL_EN
    // Reset on the 10th MUL cycle aborts the multiply.
    @(negedge clk);
    sel = 4'd9; A = 32'h0001_0000; B = 32'h0001_0000; Cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mul busy in_ready", 64'({out_valid, in_ready}), 64'(2'b00));
    rst = 1'b1; in_valid = 1'b1; sel = 4'd6;
    @(negedge clk);
`else
    // Reset while a result is pending discards it.
    @(negedge clk);
    sel = 4'd1; A = 32'h0000_00F0; B = 32'h0000_000F; Cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("done before reset", 64'(out_valid), 64'(1));
    rst = 1'b1; in_valid = 1'b1; sel = 4'd6;
    @(negedge clk);
`endif
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("abort out_valid", 64'(out_valid), 64'(0));
    checkOutput("abort in_ready", 64'(in_ready), 64'(1));
    checkOutput("abort Y", 64'(Y), 64'(0));
    applyStimulus(4'd6, 32'd1, 32'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits; power of two, 8 to 64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: A, B  input  WIDTH  operands.
REQ-007 SHALL have port: sel  input  4  opcode.
REQ-008 SHALL have port: Cin  input  1  carry-in, used by ADD only.
REQ-009 SHALL have port: out_valid  output  1  result registered and held.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: Y  output  WIDTH  registered result.
REQ-012 SHALL have ports: Cout, Negative, Zero, Overflow, Err  output  1 each  registered flags.

Function
REQ-013 SHALL decode sel as follows:
- 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND; all bitwise over the full WIDTH.
- 0110 ADD = A+B+Cin.
- 0111 SUB = A+~B+1.
- 1001 MUL.
- 1010 SHL, 1100 SHR logical, 1101 SRA; shift amount = B[log2(WIDTH)-1:0].
- All other codes are illegal.
REQ-014 SHALL use a state machine with states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when in_valid and in_ready are both 1; inputs are ignored in every other cycle.
REQ-016 SHALL handle a non-MUL op as follows: accept in IDLE, go to DONE, and assert out_valid on the cycle after the accept cycle (latency 1).
REQ-017 SHALL execute MUL as unsigned shift-add, one multiplier bit per cycle, WIDTH cycles in state MUL, then DONE; out_valid rises exactly WIDTH+1 cycles after the accept cycle.
REQ-018 SHALL hold Y, the flags and out_valid stable in DONE until out_ready is 1; then go to IDLE, with out_valid 0 on the next cycle.
REQ-019 SHALL NOT overlap operations: no new request is accepted in the cycle in which the result is consumed.
REQ-020 SHALL set Zero = (Y == 0) for every legal op.
REQ-021 SHALL set Negative = Y[WIDTH-1] for every legal op.
REQ-022 SHALL set Cout as follows:
- ADD, SUB: carry out of bit WIDTH-1.
- MUL: 1 if the upper WIDTH bits of the 2*WIDTH-bit product are nonzero.
- SHL: last bit shifted out (0 if amount is 0).
- Bitwise ops, SHR, SRA: 0.
REQ-023 SHALL set Overflow for signed overflow on ADD and SUB only; 0 for all other ops.
REQ-024 SHALL return Y = 0, Err = 1 and all other flags 0 for an illegal opcode, with latency 1; Err = 0 for every legal op.
REQ-025 SHALL ignore Cin for every op except ADD.

Reset
REQ-026 SHALL, while rst = 1, force state IDLE, in_ready = 1 and out_valid = 0, and force Y, Cout, Negative, Zero, Overflow and Err to 0.
REQ-027 SHALL give rst priority over all other events: reset in MUL or DONE aborts the operation, the result is discarded, and the block is in IDLE on the next cycle.
REQ-028 SHALL ignore an in_valid presented in a reset cycle.

Configuration
REQ-029 SHALL use macro ALU_MUL_EN to control the multiplier:
- Defined: MUL datapath and state MUL are compiled in, and sel 1001 behaves per REQ-017.
- Undefined: no multiplier logic is built, state MUL is unreachable, and sel 1001 is handled as illegal per REQ-024.

Verification (WIDTH=32)
REQ-030 SHALL cover ADD overflow: ADD A=0x7FFFFFFF, B=1, Cin=0 -> Y=0x80000000, Overflow=1, Negative=1, Cout=0, out_valid 1 cycle after accept.
REQ-031 SHALL cover SUB to zero: SUB A=5, B=5 -> Y=0, Zero=1, Cout=1, Overflow=0.
REQ-032 SHALL cover MUL overflow: MUL A=0x00010000, B=0x00010000 (ALU_MUL_EN defined) -> Y=0, Zero=1, Cout=1, out_valid exactly 33 cycles after accept; undefined -> Err=1, Y=0, latency 1.
REQ-033 SHALL cover arithmetic shift: SRA A=0x80000000, B=4 -> Y=0xF8000000, Negative=1, Cout=0.
REQ-034 SHALL cover backpressure: result pending, out_ready=0 for 5 cycles with in_valid=1 -> Y and flags unchanged, in_ready=0, no request accepted; out_ready=1 -> IDLE on the next cycle.
REQ-035 SHALL cover reset mid-MUL: rst=1 on the 10th MUL cycle -> next cycle out_valid=0, in_ready=1, Y=0; a following ADD 1+1 returns Y=2.
